tb_traffic_gen: RTL
===================

// Module: tb_traffic_gen
//
// PURPOSE
// - AXI4-Stream packet generator driving card_sim's ingress in the top-level simulation bench.
// - Emits a programmable number of packets: one header beat plus LFSR payload beats.
// - Downstream checkers regenerate the payload from the same seed for bit-exact comparison.
// - Synthesizable RTL, so it can also be dropped into on-card loopback self-test.
//
// PARAMETERS
// - DW     512            tdata width in bits; multiple of 32, >= 64
// - POLY   32'h80200003   Galois LFSR taps (x^32+x^22+x^2+x+1)
//
// PORTS
// - clk             in   1       single clock for all logic
// - rst             in   1       asynchronous, active-high reset
// - start           in   1       1-cycle pulse; latches cfg_* and begins a run
// - cfg_pkt_len     in   16      beats per packet including header; values <2 clamp to 2
// - cfg_pkt_num     in   32      packets per run; 0 means the run completes immediately
// - cfg_gap         in   8       idle cycles (tvalid=0) after each tlast handshake
// - cfg_seed        in   32      LFSR seed; 0 is replaced by 32'h1
// - m_axis_tdata    out  DW      stream data
// - m_axis_tkeep    out  DW/8    always all-ones while tvalid=1; 0 otherwise
// - m_axis_tvalid   out  1       stream valid
// - m_axis_tready   in   1       stream ready from card_sim
// - m_axis_tlast    out  1       last beat of packet
// - busy            out  1       run in progress
// - done            out  1       sticky run-complete flag; cleared by next accepted start
// - pkt_sent        out  32      packets fully accepted (tlast handshakes) in current run
//
// BEHAVIOUR
// - Reset: state IDLE; tvalid, tlast, busy, done = 0; tdata, tkeep, pkt_sent = 0; LFSR = 1.
// - Handshake: beat transfers when tvalid & tready. Once tvalid=1, tvalid/tdata/tlast hold until transfer.
// - FSM: IDLE -> HDR -> DATA -> (GAP) -> HDR ... -> FIN.
//   - start is accepted only in IDLE or FIN and is ignored while busy.
//   - On accept: latch cfg (length clamped, seed fixed); LFSR = seed; pkt_sent = 0; done = 0; busy = 1.
//     - If cfg_pkt_num == 0: go to FIN; done = 1 next cycle.
//     - Otherwise: go to HDR; tvalid = 1 on the following cycle (1-cycle start latency).
//   - HDR: tdata[63:0] = {seq[31:0], len[15:0], 16'hA5A5}; upper bits 0; seq is the 0-based packet index.
//   - DATA: tdata = LFSR state replicated DW/32 times.
//     - LFSR steps once per accepted data beat and is never reset between packets.
//     - Beat counter counts 1..len-1; tlast = 1 on beat len-1.
//   - On tlast transfer: pkt_sent += 1.
//     - If pkt_sent reaches pkt_num: go to FIN (busy = 0, done = 1, tvalid = 0).
//     - Else if gap != 0: go to GAP for exactly gap cycles with tvalid = 0.
//     - Else: go straight to HDR with no bubble.
//   - FIN: behaves as IDLE, but done stays 1.
// - Arithmetic: beat counter 16 bits, pkt_sent 32 bits; no wrap within a legal run.
// - Reset mid-packet: tvalid drops asynchronously; no tlast is emitted; the run is abandoned.
// - Backpressure: tready = 0 for any duration stalls the FSM, LFSR and counters; the gap counter runs only in GAP.
//
// STRUCTURE
// - tb_traffic_pkg holds:
//   - state enum (IDLE, HDR, DATA, GAP, FIN)
//   - HDR_MAGIC = 16'hA5A5
//   - default POLY and DEFAULT_SEED = 32'h1
//   - a function hdr_word(seq, len), shared with the checker
// - Sub-module tb_lfsr32: seed load, step enable, POLY parameter, 32-bit state out.
//   - Reused unchanged by the downstream checker.
//
// TESTING
// - Basic run: len=4, num=2, gap=0, seed=1, tready=1.
//   - Expect 8 beats on consecutive cycles; tlast on beats 3 and 7.
//   - Header 1 low word = 64'h00000001_0004_A5A5.
//   - pkt_sent = 2, done = 1.
// - Clamp and gap: len=1, num=3, gap=5.
//   - Each packet is 2 beats.
//   - Exactly 5 tvalid=0 cycles between packets; none after the last packet.
// - Backpressure: tready randomly 0 on 50% of cycles.
//   - tdata/tlast stable while tvalid & !tready.
//   - Payload sequence identical to the tready=1 run with the same seed.
// - Zero work: num=0.
//   - done = 1 two cycles after start; tvalid never asserts.
//   - seed=0 run matches the seed=1 payload.
// - Start while busy: pulse start mid-packet.
//   - Pulse is ignored; the run completes with the original config.
// - Reset mid-packet: assert rst during beat 2 of 4.
//   - tvalid = 0 immediately; busy = 0; pkt_sent = 0.
//   - A fresh start reproduces the first packet exactly.

Source files
------------

// File: rtl/tb_traffic_pkg.sv
// tb_traffic_pkg: shared states, constants and header format for the traffic generator and its checker
package tb_traffic_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, GAP, FIN} state_e;
  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;
  localparam logic [31:0] DEFAULT_POLY = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'h1;
  function automatic logic [63:0] hdr_word(input logic [31:0] seq, input logic [15:0] len);
    return {seq, len, HDR_MAGIC};
  endfunction
endpackage

// File: rtl/tb_lfsr32.sv
// tb_lfsr32: right-shifting Galois LFSR with seed load and step enable
module tb_lfsr32 import tb_traffic_pkg::*; #(
  parameter logic [31:0] POLY = DEFAULT_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] state_o
);
  logic [31:0] state_q, state_d;
  always_comb state_d = load_i ? seed_i :
                        step_i ? ({1'b0, state_q[31:1]} ^ (state_q[0] ? POLY : 32'h0)) : state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= DEFAULT_SEED;
    else     state_q <= state_d;
  assign state_o = state_q;
endmodule

// File: rtl/tb_traffic_gen.sv
// tb_traffic_gen: AXI4-Stream packet generator emitting a header beat plus LFSR payload per packet
module tb_traffic_gen import tb_traffic_pkg::*; #(
  parameter int          DW   = 512,
  parameter logic [31:0] POLY = DEFAULT_POLY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     cfg_pkt_len,
  input  logic [31:0]     cfg_pkt_num,
  input  logic [7:0]      cfg_gap,
  input  logic [31:0]     cfg_seed,
  output logic [DW-1:0]   m_axis_tdata,
  output logic [DW/8-1:0] m_axis_tkeep,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic            busy,
  output logic            done,
  output logic [31:0]     pkt_sent
);
  state_e      state_q, state_d;
  logic [15:0] len_q, len_d, beat_q, beat_d;
  logic [31:0] num_q, num_d, pkt_q, pkt_d, lfsr, seed_fix;
  logic [7:0]  gap_q, gap_d, gcnt_q, gcnt_d;
  logic        busy_q, busy_d, done_q, done_d, accept, xfer, fin;

  assign accept        = start && !busy_q && (state_q == IDLE || state_q == FIN);
  assign m_axis_tvalid = state_q == HDR || state_q == DATA;
  assign m_axis_tlast  = state_q == DATA && beat_q == len_q - 16'd1;
  assign m_axis_tkeep  = {(DW/8){m_axis_tvalid}};
  assign m_axis_tdata  = state_q == HDR  ? {{(DW-64){1'b0}}, hdr_word(pkt_q, len_q)} :
                         state_q == DATA ? {(DW/32){lfsr}} : '0;
  assign xfer          = m_axis_tvalid && m_axis_tready;
  assign fin           = pkt_q + 32'd1 == num_q;
  assign seed_fix      = cfg_seed == 32'd0 ? DEFAULT_SEED : cfg_seed;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_sent      = pkt_q;

  // The LFSR advances only on accepted payload beats, so stalls never disturb the sequence
  tb_lfsr32 #(.POLY(POLY)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .seed_i  (seed_fix),
    .step_i  (xfer && state_q == DATA),
    .state_o (lfsr)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    num_d   = num_q;
    gap_d   = gap_q;
    beat_d  = beat_q;
    gcnt_d  = gcnt_q;
    pkt_d   = pkt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (state_q == FIN) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (accept) begin
      len_d   = cfg_pkt_len < 16'd2 ? 16'd2 : cfg_pkt_len;
      num_d   = cfg_pkt_num;
      gap_d   = cfg_gap;
      pkt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      state_d = cfg_pkt_num == 32'd0 ? FIN : HDR;
    end else if (state_q == HDR && xfer) begin
      state_d = DATA;
      beat_d  = 16'd1;
    end else if (state_q == DATA && xfer) begin
      beat_d = beat_q + 16'd1;
      if (m_axis_tlast) begin
        pkt_d   = pkt_q + 32'd1;
        gcnt_d  = gap_q;
        busy_d  = !fin;
        done_d  = fin;
        state_d = fin ? FIN : gap_q != 8'd0 ? GAP : HDR;
      end
    end else if (state_q == GAP) begin
      gcnt_d  = gcnt_q - 8'd1;
      state_d = gcnt_q == 8'd1 ? HDR : GAP;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      beat_q  <= '0;
      gcnt_q  <= '0;
      pkt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      num_q   <= num_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
      gcnt_q  <= gcnt_d;
      pkt_q   <= pkt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
endmodule
